// File: rtl/xnor_cell_sched_if.sv
// Bundle of request/grant, result and RSFQ cell pulse signals for xnor_cell_sched.
// The slave modport is the scheduler; master is whatever drives requests and models the cell.
interface xnor_cell_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] opa;
    logic [NREQ-1:0] opb;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic            result;
    logic [IDW-1:0]  result_id;
    logic            cell_a;
    logic            cell_b;
    logic            cell_clk;
    logic            cell_q;
    logic            err;

    modport slave (
        input  req, opa, opb, cell_q,
        output gnt, busy, done, result, result_id, cell_a, cell_b, cell_clk, err
    );

    modport master (
        output req, opa, opb, cell_q,
        input  gnt, busy, done, result, result_id, cell_a, cell_b, cell_clk, err
    );
endinterface

// File: rtl/xnor_cell_sched.sv
// Round-robin scheduler sharing one toggle-coded RSFQ XNOR cell among NREQ requesters.
// Optional result self-check enabled by defining XNOR_SCHED_SELFCHECK_EN.
module xnor_cell_sched #(
    parameter int NREQ    = 4,
    parameter int T_AB    = 2,
    parameter int T_SETUP = 2,
    parameter int T_Q     = 3
) (
    input logic             clk,
    input logic             rst_n,
    xnor_cell_sched_if.slave bus
);
    localparam int IDW  = $clog2(NREQ);
    localparam int TMAX = (T_AB > T_SETUP) ? ((T_AB > T_Q) ? T_AB : T_Q)
                                           : ((T_SETUP > T_Q) ? T_SETUP : T_Q);
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_CLOCK,
        S_SAMPLE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            done_q;
    logic            result_q;
    logic [IDW-1:0]  resultId_q;
    logic [IDW-1:0]  grantId_q;
    logic [IDW-1:0]  rrPtr_q;
    logic            opa_q;
    logic            opb_q;
    logic            cellA_q;
    logic            cellB_q;
    logic            cellClk_q;
    logic            qRef_q;

    logic            anyReq;
    logic [IDW-1:0]  grantId_d;
    logic [IDW-1:0]  rrPtr_d;
    logic            result_d;

    // First requester at or after the pointer wins; the pointer then moves just past it.
    always_comb begin
        int idx;
        idx       = 0;
        anyReq    = 1'b0;
        grantId_d = '0;
        rrPtr_d   = rrPtr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rrPtr_q) + k) % NREQ;
            if (!anyReq && bus.req[idx]) begin
                anyReq    = 1'b1;
                grantId_d = IDW'(idx);
                rrPtr_d   = IDW'((idx + 1) % NREQ);
            end
        end
    end

    assign result_d = (bus.cell_q != qRef_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FLUSH;
            cnt_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
            resultId_q <= '0;
            grantId_q  <= '0;
            rrPtr_q    <= '0;
            opa_q      <= 1'b0;
            opb_q      <= 1'b0;
            cellA_q    <= 1'b0;
            cellB_q    <= 1'b0;
            cellClk_q  <= 1'b0;
            qRef_q     <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                // A lone clock pulse empties the cell; any q toggle it causes lands in qRef.
                S_FLUSH: begin
                    if (cnt_q == '0) cellClk_q <= ~cellClk_q;
                    if (cnt_q == CW'(T_Q)) begin
                        qRef_q  <= bus.cell_q;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (anyReq) begin
                        gnt_q[grantId_d] <= 1'b1;
                        busy_q           <= 1'b1;
                        opa_q            <= bus.opa[grantId_d];
                        opb_q            <= bus.opb[grantId_d];
                        grantId_q        <= grantId_d;
                        rrPtr_q          <= rrPtr_d;
                        cnt_q            <= '0;
                        state_q          <= S_ISSUE_A;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_ISSUE_A: begin
                    if (cnt_q == '0 && opa_q) cellA_q <= ~cellA_q;
                    if (cnt_q == CW'(T_AB - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_ISSUE_B;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ISSUE_B: begin
                    if (cnt_q == '0 && opb_q) cellB_q <= ~cellB_q;
                    if (cnt_q == CW'(T_SETUP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_CLOCK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CLOCK: begin
                    if (cnt_q == '0) cellClk_q <= ~cellClk_q;
                    if (cnt_q == CW'(T_Q - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    result_q   <= result_d;
                    qRef_q     <= bus.cell_q;
                    resultId_q <= grantId_q;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_FLUSH;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef XNOR_SCHED_SELFCHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == S_SAMPLE && result_d != ~(opa_q ^ opb_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_id = resultId_q;
    assign bus.cell_a    = cellA_q;
    assign bus.cell_b    = cellB_q;
    assign bus.cell_clk  = cellClk_q;
endmodule

// File: tb/tb_xnor_cell_sched.sv
// Directed bench for xnor_cell_sched with a behavioural toggle-coded XNOR cell model.
module tb_xnor_cell_sched;
    localparam int NREQ = 4;

    logic clk;
    logic rst_n;
    logic faultNoQ;
    logic cellQ;
    logic prevA, prevB, prevClk;
    int   pulses;
    int   testsRun;
    int   testsFailed;

    xnor_cell_sched_if #(.NREQ(NREQ)) bus ();

    xnor_cell_sched #(
        .NREQ(NREQ), .T_AB(2), .T_SETUP(2), .T_Q(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cell model: even pulse count at a clock edge toggles q one cycle later.
    initial begin
        cellQ   = 1'b0;
        prevA   = 1'b0;
        prevB   = 1'b0;
        prevClk = 1'b0;
        pulses  = 0;
    end

    always @(posedge clk) begin
        int p;
        p = pulses;
        if (bus.cell_a !== prevA) p = p + 1;
        if (bus.cell_b !== prevB) p = p + 1;
        if (bus.cell_clk !== prevClk) begin
            if (!faultNoQ && (p % 2) == 0) cellQ <= ~cellQ;
            p = 0;
        end
        pulses  <= p;
        prevA   <= bus.cell_a;
        prevB   <= bus.cell_b;
        prevClk <= bus.cell_clk;
    end

    assign bus.cell_q = cellQ;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] a,
                                 input logic [NREQ-1:0] b);
        bus.req = r;
        bus.opa = a;
        bus.opb = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits for a grant, then traces the eight cycles up to done against the fixed slot timing.
    task automatic runOp(input string tag, input int expId, input logic expA, input logic expB,
                         input logic expRes, input int expWait, input logic dropReq);
        int          waited;
        logic        pa, pb, pc;
        logic [31:0] trA, trB, trC, trD, trBusy;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (bus.gnt == '0 && waited < 30);
        checkOutput({tag, ".gnt"}, 32'(bus.gnt), 32'(1) << expId);
        if (expWait > 0) checkOutput({tag, ".spacing"}, 32'(waited), 32'(expWait));
        if (dropReq) applyStimulus('0, ~bus.opa, ~bus.opb);
        pa     = bus.cell_a;
        pb     = bus.cell_b;
        pc     = bus.cell_clk;
        trA    = '0;
        trB    = '0;
        trC    = '0;
        trD    = 32'(bus.done);
        trBusy = 32'(bus.busy);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.cell_a !== pa) trA[c] = 1'b1;
            if (bus.cell_b !== pb) trB[c] = 1'b1;
            if (bus.cell_clk !== pc) trC[c] = 1'b1;
            pa        = bus.cell_a;
            pb        = bus.cell_b;
            pc        = bus.cell_clk;
            trD[c]    = bus.done;
            trBusy[c] = bus.busy;
        end
        checkOutput({tag, ".aEdge"}, trA, expA ? 32'h2 : 32'h0);
        checkOutput({tag, ".bEdge"}, trB, expB ? 32'h8 : 32'h0);
        checkOutput({tag, ".clkEdge"}, trC, 32'h20);
        checkOutput({tag, ".doneTiming"}, trD, 32'h100);
        checkOutput({tag, ".busy"}, trBusy, 32'h1FF);
        checkOutput({tag, ".result"}, 32'(bus.result), 32'(expRes));
        checkOutput({tag, ".resultId"}, 32'(bus.result_id), 32'(expId));
    endtask

    initial begin
        int   clkEdges;
        logic pc;
        logic sawDone;
        testsRun    = 0;
        testsFailed = 0;
        faultNoQ    = 1'b0;
        rst_n       = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (3) tick();

        checkOutput("reset.gnt", 32'(bus.gnt), 32'h0);
        checkOutput("reset.done", 32'(bus.done), 32'h0);
        checkOutput("reset.result", 32'(bus.result), 32'h0);
        checkOutput("reset.resultId", 32'(bus.result_id), 32'h0);
        checkOutput("reset.cells", {29'h0, bus.cell_a, bus.cell_b, bus.cell_clk}, 32'h0);
        checkOutput("reset.busy", 32'(bus.busy), 32'h1);
        checkOutput("reset.err", 32'(bus.err), 32'h0);

        // Flush: busy through T_Q+1 cycles from release, a single cell_clk edge, then idle.
        rst_n    = 1'b1;
        clkEdges = 0;
        pc       = bus.cell_clk;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("flush.busy", 32'(bus.busy), 32'h1);
            if (bus.cell_clk !== pc) clkEdges++;
            pc = bus.cell_clk;
        end
        tick();
        if (bus.cell_clk !== pc) clkEdges++;
        checkOutput("flush.idleBusy", 32'(bus.busy), 32'h0);
        checkOutput("flush.clkEdges", 32'(clkEdges), 32'h1);
        checkOutput("flush.outs", {bus.gnt, bus.done, bus.result, bus.cell_a, bus.cell_b, bus.err},
                    32'h0);

        // Operand sweep on requester 0; req and operands drop right after the grant.
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        runOp("op00", 0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        tick();
        checkOutput("op00.busyAfter", 32'(bus.busy), 32'h0);
        checkOutput("op00.doneAfter", 32'(bus.done), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0001);
        runOp("op01", 0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        runOp("op10", 0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 4'b0001);
        runOp("op11", 0, 1'b1, 1'b1, 1'b1, 0, 1'b1);

        // Mid-op reset at G+4 on requester 1.
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        sawDone = 1'b0;
        for (int k = 0; k < 30 && bus.gnt == '0; k++) tick();
        checkOutput("abort.gnt", 32'(bus.gnt), 32'h2);
        applyStimulus('0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            sawDone = sawDone | bus.done;
        end
        rst_n = 1'b0;
        tick();
        checkOutput("abort.cells", {29'h0, bus.cell_a, bus.cell_b, bus.cell_clk}, 32'h0);
        checkOutput("abort.busy", 32'(bus.busy), 32'h1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            sawDone = sawDone | bus.done;
        end
        checkOutput("abort.noDone", 32'(sawDone), 32'h0);
        checkOutput("abort.idle", 32'(bus.busy), 32'h0);
        applyStimulus(4'b1000, 4'b1000, 4'b1000);
        runOp("abort.next", 3, 1'b1, 1'b1, 1'b1, 0, 1'b1);

        // All four requesting: round robin from pointer 0, one op every 9 cycles.
        applyStimulus(4'b1111, 4'b0101, 4'b0011);
        runOp("rr0", 0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        runOp("rr1", 1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        runOp("rr2", 2, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        runOp("rr3", 3, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        runOp("rrWrap", 0, 1'b1, 1'b1, 1'b1, 1, 1'b1);

        // Cell that never toggles q: (0,0) reads back 0, err latches when the check is built in.
        faultNoQ = 1'b1;
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        runOp("fault", 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
`ifdef XNOR_SCHED_SELFCHECK_EN
        checkOutput("fault.err", 32'(bus.err), 32'h1);
`else
        checkOutput("fault.err", 32'(bus.err), 32'h0);
`endif
        faultNoQ = 1'b0;
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        runOp("afterFault", 1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
`ifdef XNOR_SCHED_SELFCHECK_EN
        checkOutput("afterFault.errSticky", 32'(bus.err), 32'h1);
`else
        checkOutput("afterFault.errSticky", 32'(bus.err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/xnor_cell_sched.md
# xnor_cell_sched

Synchronous scheduler that shares one clocked RSFQ XNOR cell among `NREQ` requesters. It performs round-robin arbitration and encodes the winner's operands as toggle-coded pulses on the cell's `a`/`b` inputs. It then fires the cell clock with fixed cycle spacing that respects the cell's hold windows, and decodes the toggle on the cell's `q` into a result bit returned with the requester ID. It sits between the CMOS-side logic and the XNOR cell.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `T_AB`, 2, cycles between the `a` slot and the `b` slot (≥1)
- `T_SETUP`, 2, cycles between the `b` slot and the cell clock (≥1)
- `T_Q`, 3, cycles from the cell clock to sampling `q` (≥1)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  reset, synchronous and active-low
- `req`  in  NREQ  per-requester request level
- `opa`  in  NREQ  per-requester operand A
- `opb`  in  NREQ  per-requester operand B
- `gnt`  out  NREQ  one-hot grant, one-cycle pulse
- `busy`  out  1  high from the grant cycle through the done cycle
- `done`  out  1  one-cycle result-valid strobe
- `result`  out  1  XNOR(opa, opb) of the granted op, valid with `done`
- `result_id`  out  $clog2(NREQ)  index of the granted requester, valid with `done`
- `cell_a`, `cell_b`, `cell_clk`  out  1 each  toggle-coded pulses to the cell; each edge is one pulse
- `cell_q`  in  1  toggle-coded cell output, synchronous to `clk`
- `err`  out  1  sticky self-check flag (see Configuration)

## Operation
States:
- **FLUSH**: entered on reset. Toggles `cell_clk` once, waits `T_Q` cycles, loads `q_ref <= cell_q`, then goes to IDLE. This clears any residual cell state (pulse-only state 1/2 returns to 0; an extra `q` toggle is absorbed by `q_ref`). `busy`=1.
- **IDLE**: if any `req` bit is set, grant the first set bit at or after `rr_ptr` (wrapping), pulse `gnt`, latch `opa`/`opb`/ID, set `rr_ptr <= winner+1 mod NREQ`, go to ISSUE_A.
- **ISSUE_A**: toggle `cell_a` iff the latched `opa`=1; wait `T_AB`.
- **ISSUE_B**: toggle `cell_b` iff the latched `opb`=1; wait `T_SETUP`.
- **CLOCK**: toggle `cell_clk`; wait `T_Q`.
- **SAMPLE**: `result <= (cell_q != q_ref)`, `q_ref <= cell_q`, pulse `done`, go to IDLE.

Rules:
- Cell encoding: a single data pulse leaves the cell in a non-zero state, so the clock produces no `q` toggle (result 0). Zero or two data pulses leave state 0, so the clock toggles `q` (result 1).
- Pulse order is fixed: `a` slot before `b` slot. Slot timing is constant regardless of operand values.
- Operands are sampled only in the grant cycle; `req` may drop afterwards.
- At most one op is in flight. `req` is ignored outside IDLE.

## Timing
- Grant in cycle G.
- `cell_a` edge at G+1.
- `cell_b` edge at G+1+T_AB.
- `cell_clk` edge at G+1+T_AB+T_SETUP.
- `done` at G+1+T_AB+T_SETUP+T_Q; this is G+8 with defaults.
- Next grant no earlier than `done`+1. Back-to-back throughput is one op per 9 cycles (defaults).
- Reset values:
  - `gnt`=0, `done`=0, `result`=0, `result_id`=0
  - `cell_a`=`cell_b`=`cell_clk`=0
  - `busy`=1 (FLUSH), `err`=0, `rr_ptr`=0
- FLUSH lasts 1+T_AB... no: the `cell_clk` toggle is in the first post-reset cycle; IDLE is reached T_Q+1 cycles after `rst_n` rises.
- Reset asserted mid-operation: the op is aborted with no `done`, outputs take reset values next edge, and FLUSH reruns after release.
- Simultaneous requests: the round-robin winner is taken; losers stay pending.
- Pointer wrap: after granting NREQ-1, the search starts at 0.

## Configuration
- `XNOR_SCHED_SELFCHECK_EN` defined: at SAMPLE, compares `result` against `~(opa^opb)` of the latched operands. Any mismatch sets `err`, which stays high until reset.
- Not defined: the check logic is absent and `err` is tied 0.

## Test plan
- Reset, cell model idle: `busy`=1 for T_Q+1 cycles, exactly one `cell_clk` edge, then `busy`=0 with all other outputs 0.
- `req`=0001, (opa,opb) swept over 00/01/10/11: `result`=1,0,0,1. `result_id`=0. `done` at G+8. The `cell_a`/`cell_b` edges occur only for 1 operands, at G+1 and G+3.
- `req`=1111 held: grants cycle through IDs 0,1,2,3,0 with 9-cycle spacing; `gnt` is always one-hot.
- Reset asserted at G+4 (mid-op): no `done`, toggles go to 0, FLUSH follows. The next op (1,1) returns `result`=1.
- With `XNOR_SCHED_SELFCHECK_EN`, a fault-injected cell that never toggles `q`: op (0,0) gives `result`=0 and `err`=1 sticky. Without the macro, `err` stays 0.
